// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles both requester ports and the DataMemory side of dmem_arbiter.
//   slave  : arbiter view (requests and i_mem_rd in, grants/responses/memory drive out)
//   master : system view (requesters and memory model drive the request side)
//   Requester N (0 = core LSU, 1 = debug/DMA):
//     i_pN_req/we/addr/wd/mask_type/ext_type in, o_pN_gnt/rvalid/rdata/err out
//   Memory: o_mem_we/addr/wd/mask_type/ext_type out, i_mem_rd in
//   Optional: i_p0_lock/i_p1_lock exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_p0_req;
    logic                  i_p0_we;
    logic [ADDR_WIDTH-1:0] i_p0_addr;
    logic [DATA_WIDTH-1:0] i_p0_wd;
    logic [1:0]            i_p0_mask_type;
    logic                  i_p0_ext_type;
    logic                  o_p0_gnt;
    logic                  o_p0_rvalid;
    logic [DATA_WIDTH-1:0] o_p0_rdata;
    logic                  o_p0_err;

    logic                  i_p1_req;
    logic                  i_p1_we;
    logic [ADDR_WIDTH-1:0] i_p1_addr;
    logic [DATA_WIDTH-1:0] i_p1_wd;
    logic [1:0]            i_p1_mask_type;
    logic                  i_p1_ext_type;
    logic                  o_p1_gnt;
    logic                  o_p1_rvalid;
    logic [DATA_WIDTH-1:0] o_p1_rdata;
    logic                  o_p1_err;

    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wd;
    logic [1:0]            o_mem_mask_type;
    logic                  o_mem_ext_type;
    logic [DATA_WIDTH-1:0] i_mem_rd;

`ifdef DMEM_ARB_LOCK_EN
    logic                  i_p0_lock;
    logic                  i_p1_lock;
`endif

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  i_p0_lock, i_p1_lock,
`endif
        input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wd, i_p0_mask_type, i_p0_ext_type,
        input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wd, i_p1_mask_type, i_p1_ext_type,
        input  i_mem_rd,
        output o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        output o_mem_we, o_mem_addr, o_mem_wd, o_mem_mask_type, o_mem_ext_type
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output i_p0_lock, i_p1_lock,
`endif
        output i_p0_req, i_p0_we, i_p0_addr, i_p0_wd, i_p0_mask_type, i_p0_ext_type,
        output i_p1_req, i_p1_we, i_p1_addr, i_p1_wd, i_p1_mask_type, i_p1_ext_type,
        output i_mem_rd,
        input  o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        input  o_mem_we, o_mem_addr, o_mem_wd, o_mem_mask_type, o_mem_ext_type
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter/sequencer in front of the single-port DataMemory.
//   Port 0 = core load/store unit, port 1 = debug/DMA master.
//   Pipeline: accept (combinational grant, fields latched) -> ACCESS (memory
//   driven from latches, read data captured) -> RESP (one-cycle rvalid pulse).
//   Misaligned halfword/word and reserved-size accesses occupy a slot but never
//   write memory; they answer with err=1, rdata=0.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : dmem_arbiter_if.slave (both requester ports + DataMemory side)
// Optional feature macro: DMEM_ARB_LOCK_EN (adds lock inputs and ARB/LOCK0/LOCK1
//   FSM for atomic read-modify-write sequences).
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] CNT_MAX = 4'(MAX_CONSEC);

    logic [3:0]            consec_cnt;
    logic                  gnt0;
    logic                  gnt1;
    logic                  hold0;
    logic                  hold1;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wd;
    logic [1:0]            sel_mask;
    logic                  sel_ext;
    logic                  sel_err;

    logic                  acc_valid;
    logic                  acc_port;
    logic                  acc_err;
    logic                  acc_load;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;
    arb_state_t state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ARB;
        end else if (gnt0) begin
            state <= bus.i_p0_lock ? LOCK0 : ARB;
        end else if (gnt1) begin
            state <= bus.i_p1_lock ? LOCK1 : ARB;
        end
    end

    assign hold0 = (state == LOCK0);
    assign hold1 = (state == LOCK1);
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    // Port 0 has priority until it has won MAX_CONSEC times in a row while
    // port 1 waited; a held lock restricts grants to the lock owner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst) begin
            if (hold0) begin
                gnt0 = bus.i_p0_req;
            end else if (hold1) begin
                gnt1 = bus.i_p1_req;
            end else if (bus.i_p0_req && bus.i_p1_req) begin
                gnt1 = (consec_cnt == CNT_MAX);
                gnt0 = !gnt1;
            end else begin
                gnt0 = bus.i_p0_req;
                gnt1 = bus.i_p1_req;
            end
        end
    end

    assign bus.o_p0_gnt = gnt0;
    assign bus.o_p1_gnt = gnt1;

    always_comb begin
        if (gnt1) begin
            sel_we   = bus.i_p1_we;
            sel_addr = bus.i_p1_addr;
            sel_wd   = bus.i_p1_wd;
            sel_mask = bus.i_p1_mask_type;
            sel_ext  = bus.i_p1_ext_type;
        end else begin
            sel_we   = bus.i_p0_we;
            sel_addr = bus.i_p0_addr;
            sel_wd   = bus.i_p0_wd;
            sel_mask = bus.i_p0_mask_type;
            sel_ext  = bus.i_p0_ext_type;
        end
        sel_err = 1'b0;
        case (sel_mask)
            2'b00:   sel_err = 1'b0;
            2'b01:   sel_err = sel_addr[0];
            2'b10:   sel_err = |sel_addr[1:0];
            default: sel_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            consec_cnt          <= '0;
            acc_valid           <= 1'b0;
            acc_port            <= 1'b0;
            acc_err             <= 1'b0;
            acc_load            <= 1'b0;
            bus.o_mem_we        <= 1'b0;
            bus.o_mem_addr      <= '0;
            bus.o_mem_wd        <= '0;
            bus.o_mem_mask_type <= '0;
            bus.o_mem_ext_type  <= 1'b0;
            bus.o_p0_rvalid     <= 1'b0;
            bus.o_p0_err        <= 1'b0;
            bus.o_p0_rdata      <= '0;
            bus.o_p1_rvalid     <= 1'b0;
            bus.o_p1_err        <= 1'b0;
            bus.o_p1_rdata      <= '0;
        end else begin
            // Fairness counter is frozen while a lock is held.
            if (!(hold0 || hold1)) begin
                if (gnt1 || !bus.i_p1_req) begin
                    consec_cnt <= '0;
                end else if (gnt0 && consec_cnt != CNT_MAX) begin
                    consec_cnt <= consec_cnt + 4'd1;
                end
            end

            // Accept -> ACCESS. Address/data hold their last value when idle.
            acc_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                acc_port            <= gnt1;
                acc_err             <= sel_err;
                acc_load            <= !sel_we;
                bus.o_mem_we        <= sel_we && !sel_err;
                bus.o_mem_addr      <= sel_addr;
                bus.o_mem_wd        <= sel_wd;
                bus.o_mem_mask_type <= sel_mask;
                bus.o_mem_ext_type  <= sel_ext;
            end else begin
                bus.o_mem_we        <= 1'b0;
            end

            // ACCESS -> RESP. Only the owning port sees the pulse; the other
            // port's response fields stay zero.
            bus.o_p0_rvalid <= acc_valid && !acc_port;
            bus.o_p1_rvalid <= acc_valid && acc_port;
            bus.o_p0_err    <= acc_valid && !acc_port && acc_err;
            bus.o_p1_err    <= acc_valid && acc_port && acc_err;
            bus.o_p0_rdata  <= (acc_valid && !acc_port && acc_load && !acc_err) ? bus.i_mem_rd : '0;
            bus.o_p1_rdata  <= (acc_valid && acc_port && acc_load && !acc_err) ? bus.i_mem_rd : '0;
        end
    end
endmodule
